assoc_cache: RTL and testbench

ASSOC_CACHE -- requirements
Module: assoc_cache

---
 rtl/assoc_cache.sv | 202 ++++++++++++++++++++
 tb/tb_assoc_cache.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_cache.sv
// rtl/assoc_cache.sv - 2-way set-associative write-back, write-allocate cache
// with line-granular memory interface and saturating hit/miss statistics.
module assoc_cache #(
   parameter int ADDR_W  = 10,
   parameter int WORD_W  = 10,
   parameter int INDEX_W = 4,
   parameter int OFF_W   = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              cpu_req,
   input  logic                              cpu_rw,
   input  logic [ADDR_W-1:0]                 cpu_addr,
   input  logic [WORD_W-1:0]                 cpu_wdata,
   output logic                              cpu_ready,
   output logic                              cpu_done,
   output logic [WORD_W-1:0]                 cpu_rdata,
   output logic                              mem_req,
   output logic                              mem_rw,
   output logic [ADDR_W-OFF_W-1:0]           mem_addr,
   output logic [(2**OFF_W)*WORD_W-1:0]      mem_wdata,
   input  logic [(2**OFF_W)*WORD_W-1:0]      mem_rdata,
   input  logic                              mem_ready,
   output logic [15:0]                       hit_cnt,
   output logic [15:0]                       miss_cnt
);

   localparam int WORDS  = 2**OFF_W;
   localparam int SETS   = 2**INDEX_W;
   localparam int TAG_W  = ADDR_W - INDEX_W - OFF_W;
   localparam int LINE_W = WORDS * WORD_W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COMPARE,
      S_WRITEBACK,
      S_ALLOCATE
   } state_t;

   state_t               state_q, state_d;
   logic                 rw_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [WORD_W-1:0]    wdata_q;
   logic                 replay_q, replay_d;
   logic                 victim_q, victim_d;
   logic [15:0]          hit_cnt_q, hit_cnt_d;
   logic [15:0]          miss_cnt_q, miss_cnt_d;
   logic [1:0][SETS-1:0] valid_q;
   logic [1:0][SETS-1:0] dirty_q;
   logic [SETS-1:0]      lru_q;

   logic [TAG_W-1:0]     tag_q  [2][SETS];
   logic [LINE_W-1:0]    line_q [2][SETS];

   logic [TAG_W-1:0]     req_tag;
   logic [INDEX_W-1:0]   req_idx;
   logic [OFF_W-1:0]     req_off;
   logic                 hit0, hit1, hit, hit_way;
   logic                 miss_victim;
   logic [LINE_W-1:0]    hit_line, merged_line;
   logic [WORD_W-1:0]    hit_word;
   logic                 latch_en, hit_en, fill_en;

   assign req_tag = addr_q[ADDR_W-1 -: TAG_W];
   assign req_idx = addr_q[OFF_W +: INDEX_W];
   assign req_off = addr_q[OFF_W-1:0];

   assign hit0    = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
   assign hit1    = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
   assign hit     = hit0 | hit1;
   assign hit_way = hit1 & ~hit0;

   // Invalid ways are filled first (way 0 preferred) before evicting by LRU.
   assign miss_victim = !valid_q[0][req_idx] ? 1'b0 :
                        !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];

   assign hit_line = line_q[hit_way][req_idx];
   assign hit_word = hit_line[req_off*WORD_W +: WORD_W];

   always_comb begin
      merged_line = hit_line;
      merged_line[req_off*WORD_W +: WORD_W] = wdata_q;
   end

   assign hit_en  = (state_q == S_COMPARE) && hit;
   assign fill_en = (state_q == S_ALLOCATE) && mem_ready;

   always_comb begin
      state_d    = state_q;
      replay_d   = replay_q;
      victim_d   = victim_q;
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      latch_en   = 1'b0;
      cpu_ready  = 1'b0;
      cpu_done   = 1'b0;
      cpu_rdata  = '0;
      mem_req    = 1'b0;
      mem_rw     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      case (state_q)
         S_IDLE: begin
            cpu_ready = 1'b1;
            if (cpu_req) begin
               latch_en = 1'b1;
               replay_d = 1'b0;
               state_d  = S_COMPARE;
            end
         end
         S_COMPARE: begin
            if (hit) begin
               cpu_done  = 1'b1;
               cpu_rdata = hit_word;
               state_d   = S_IDLE;
               if (!replay_q && hit_cnt_q != 16'hFFFF) begin
                  hit_cnt_d = hit_cnt_q + 16'd1;
               end
            end else begin
               if (miss_cnt_q != 16'hFFFF) begin
                  miss_cnt_d = miss_cnt_q + 16'd1;
               end
               victim_d = miss_victim;
               if (valid_q[miss_victim][req_idx] && dirty_q[miss_victim][req_idx]) begin
                  state_d = S_WRITEBACK;
               end else begin
                  state_d = S_ALLOCATE;
               end
            end
         end
         S_WRITEBACK: begin
            mem_req   = 1'b1;
            mem_rw    = 1'b1;
            mem_addr  = {tag_q[victim_q][req_idx], req_idx};
            mem_wdata = line_q[victim_q][req_idx];
            if (mem_ready) begin
               state_d = S_ALLOCATE;
            end
         end
         S_ALLOCATE: begin
            mem_req  = 1'b1;
            mem_addr = {req_tag, req_idx};
            if (mem_ready) begin
               replay_d = 1'b1;
               state_d  = S_COMPARE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         rw_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         replay_q   <= 1'b0;
         victim_q   <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         valid_q    <= '0;
         dirty_q    <= '0;
         lru_q      <= '0;
      end else begin
         state_q    <= state_d;
         replay_q   <= replay_d;
         victim_q   <= victim_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         if (latch_en) begin
            rw_q    <= cpu_rw;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
         end
         if (fill_en) begin
            valid_q[victim_q][req_idx] <= 1'b1;
            dirty_q[victim_q][req_idx] <= 1'b0;
         end
         if (hit_en) begin
            lru_q[req_idx] <= ~hit_way;
            if (rw_q) begin
               dirty_q[hit_way][req_idx] <= 1'b1;
            end
         end
      end
   end

   // Tag/data storage needs no reset: it is only observed through valid bits.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_q[victim_q][req_idx]  <= req_tag;
         line_q[victim_q][req_idx] <= mem_rdata;
      end else if (hit_en && rw_q) begin
         line_q[hit_way][req_idx] <= merged_line;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_assoc_cache.sv
// tb/tb_assoc_cache.sv - directed self-checking bench for assoc_cache
// with a latency-programmable line memory responder.
module tb_assoc_cache;

   logic        clk;
   logic        rst;
   logic        cpu_req;
   logic        cpu_rw;
   logic [9:0]  cpu_addr;
   logic [9:0]  cpu_wdata;
   logic        cpu_ready;
   logic        cpu_done;
   logic [9:0]  cpu_rdata;
   logic        mem_req;
   logic        mem_rw;
   logic [8:0]  mem_addr;
   logic [19:0] mem_wdata;
   logic [19:0] mem_rdata;
   logic        mem_ready;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   int total = 0;
   int bad   = 0;
   int mem_lat = 3;
   int mem_cnt = 0;

   logic        log_rw   [$];
   logic [8:0]  log_addr [$];
   logic [19:0] log_wd   [$];

   assoc_cache dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_rw    (cpu_rw),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ready (cpu_ready),
      .cpu_done  (cpu_done),
      .cpu_rdata (cpu_rdata),
      .mem_req   (mem_req),
      .mem_rw    (mem_rw),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Memory responder: logs each transfer once and raises mem_ready on its mem_lat-th cycle.
   initial begin
      mem_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_ready) begin
            mem_ready = 1'b0;
            mem_cnt   = 0;
         end else if (mem_req) begin
            mem_cnt++;
            if (mem_cnt == 1) begin
               log_rw.push_back(mem_rw);
               log_addr.push_back(mem_addr);
               log_wd.push_back(mem_wdata);
            end
            if (mem_cnt >= mem_lat) mem_ready = 1'b1;
         end else begin
            mem_cnt = 0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            check("done_and_mem_req_exclusive", {31'd0, cpu_done & mem_req}, 32'd0);
            if (cpu_done === 1'b0) check("rdata_zero_when_idle", {22'd0, cpu_rdata}, 32'd0);
         end
      end
   end

   task automatic access(input logic rw, input logic [9:0] addr, input logic [9:0] wd,
                         output logic [9:0] rd, output int cyc);
      cpu_req   = 1'b1;
      cpu_rw    = rw;
      cpu_addr  = addr;
      cpu_wdata = wd;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      cyc = 0;
      rd  = '0;
      while (cyc < 200 && cpu_done !== 1'b1) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("access_timeout", {31'd0, cyc < 200}, 32'd1);
      rd = cpu_rdata;
      @(posedge clk); #1;
   endtask

   logic [9:0] rd;
   int         cyc;
   logic [5:0] done_bits, ready_bits;

   initial begin
      rst       = 1'b0;
      cpu_req   = 1'b0;
      cpu_rw    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_cpu_ready", {31'd0, cpu_ready}, 32'd1);
      check("rst_cpu_done",  {31'd0, cpu_done},  32'd0);
      check("rst_mem_req",   {31'd0, mem_req},   32'd0);
      check("rst_mem_rw",    {31'd0, mem_rw},    32'd0);
      check("rst_mem_addr",  {23'd0, mem_addr},  32'd0);
      check("rst_mem_wdata", {12'd0, mem_wdata}, 32'd0);
      check("rst_cpu_rdata", {22'd0, cpu_rdata}, 32'd0);
      check("rst_hit_cnt",   {16'd0, hit_cnt},   32'd0);
      check("rst_miss_cnt",  {16'd0, miss_cnt},  32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Cold read of 50 (tag 1, set 9): fill from line 25 after 3 cycles.
      mem_lat = 3;
      mem_rdata = 20'h0A0B5;
      log_rw.delete(); log_addr.delete(); log_wd.delete();
      access(1'b0, 10'd50, 10'd0, rd, cyc);
      check("cold_rdata",    {22'd0, rd}, 32'h0B5);
      check("cold_latency",  cyc, 4);
      check("cold_xfers",    log_addr.size(), 1);
      check("cold_fill_rw",  {31'd0, log_rw[0]}, 32'd0);
      check("cold_fill_addr", {23'd0, log_addr[0]}, 32'd25);
      check("cold_miss_cnt", {16'd0, miss_cnt}, 32'd1);
      check("cold_hit_cnt",  {16'd0, hit_cnt},  32'd0);

      // Write 300 to 51, read it back: both hit without memory traffic.
      log_rw.delete(); log_addr.delete(); log_wd.delete();
      access(1'b1, 10'd51, 10'd300, rd, cyc);
      check("wr_hit_latency", cyc, 0);
      access(1'b0, 10'd51, 10'd0, rd, cyc);
      check("rd_hit_latency", cyc, 0);
      check("rd_hit_rdata",   {22'd0, rd}, 32'd300);
      check("hit_no_mem",     log_addr.size(), 0);
      check("hit_cnt_two",    {16'd0, hit_cnt}, 32'd2);

      // 306 fills the empty way 1; 562 evicts dirty LRU way 0.
      mem_rdata = 20'h12345;
      access(1'b0, 10'd306, 10'd0, rd, cyc);
      check("fill_way1_rdata", {22'd0, rd}, 32'h345);
      check("fill_way1_xfers", log_addr.size(), 1);
      check("fill_way1_addr",  {23'd0, log_addr[0]}, 32'd153);
      log_rw.delete(); log_addr.delete(); log_wd.delete();
      mem_rdata = 20'h54321;
      access(1'b0, 10'd562, 10'd0, rd, cyc);
      check("evict_rdata",   {22'd0, rd}, 32'h321);
      check("evict_latency", cyc, 8);
      check("evict_xfers",   log_addr.size(), 2);
      check("wb_rw",         {31'd0, log_rw[0]}, 32'd1);
      check("wb_addr",       {23'd0, log_addr[0]}, 32'd25);
      check("wb_wdata",      {12'd0, log_wd[0]}, {12'd0, 10'd300, 10'h0B5});
      check("refill_rw",     {31'd0, log_rw[1]}, 32'd0);
      check("refill_addr",   {23'd0, log_addr[1]}, 32'd281);
      check("evict_miss_cnt", {16'd0, miss_cnt}, 32'd3);
      access(1'b0, 10'd306, 10'd0, rd, cyc);
      check("way1_kept_rdata", {22'd0, rd}, 32'h345);
      check("way1_kept_lat",   cyc, 0);
      check("hit_cnt_three",   {16'd0, hit_cnt}, 32'd3);

      // Request held high: completions every other cycle, ready low in COMPARE.
      cpu_req  = 1'b1;
      cpu_rw   = 1'b0;
      cpu_addr = 10'd306;
      done_bits  = '0;
      ready_bits = '0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         done_bits  = {done_bits[4:0], cpu_done};
         ready_bits = {ready_bits[4:0], cpu_ready};
      end
      cpu_req = 1'b0;
      check("b2b_done_pattern",  {26'd0, done_bits},  32'b101010);
      check("b2b_ready_pattern", {26'd0, ready_bits}, 32'b010101);
      check("b2b_hit_cnt",       {16'd0, hit_cnt},    32'd6);

      // Reset asserted mid-ALLOCATE abandons the fill.
      mem_lat = 10;
      cpu_req  = 1'b1;
      cpu_rw   = 1'b0;
      cpu_addr = 10'd100;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      @(posedge clk); #1;
      check("alloc_mem_req",  {31'd0, mem_req},  32'd1);
      check("alloc_mem_addr", {23'd0, mem_addr}, 32'd50);
      #2;
      rst = 1'b0;
      #1;
      check("rst_mid_mem_req",   {31'd0, mem_req},   32'd0);
      check("rst_mid_cpu_ready", {31'd0, cpu_ready}, 32'd1);
      check("rst_mid_miss_cnt",  {16'd0, miss_cnt},  32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      mem_lat = 3;
      mem_rdata = 20'h2A5C3;
      log_rw.delete(); log_addr.delete(); log_wd.delete();
      access(1'b0, 10'd100, 10'd0, rd, cyc);
      check("post_rst_latency",  cyc, 4);
      check("post_rst_rdata",    {22'd0, rd}, 32'h1C3);
      check("post_rst_xfers",    log_addr.size(), 1);
      check("post_rst_miss_cnt", {16'd0, miss_cnt}, 32'd1);

      // Saturation: preload the miss counter one short of full, then miss twice.
      force dut.miss_cnt_q = 16'hFFFE;
      @(posedge clk); #1;
      release dut.miss_cnt_q;
      check("sat_preload", {16'd0, miss_cnt}, 32'hFFFE);
      mem_lat = 1;
      mem_rdata = 20'h00077;
      access(1'b0, 10'd200, 10'd0, rd, cyc);
      check("same_cycle_ready_lat", cyc, 2);
      check("sat_reach", {16'd0, miss_cnt}, 32'hFFFF);
      access(1'b0, 10'd400, 10'd0, rd, cyc);
      check("sat_hold",  {16'd0, miss_cnt}, 32'hFFFF);
      check("sat_rdata", {22'd0, rd}, 32'h077);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
